// File: rtl/cpu_pkg.sv
// Shared constants for the cpu core and its boot sequencer: word width and the
// boot FSM state encoding, which is also visible on the sequencer's state output.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/boot_store.sv
// Program store for the boot sequencer: RAM_SIZE x WORD_W registers with one
// write port, a whole-array clear, and a flattened read-out bus for the core.
module boot_store
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 16,
  parameter int unsigned AW       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [WORD_W-1:0]          wdata,
  output logic [RAM_SIZE*WORD_W-1:0] ram_flat
);

  logic [WORD_W-1:0] mem_q [RAM_SIZE];

  // Word storage; clear wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < RAM_SIZE; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Flatten: word i occupies bits [(i+1)*WORD_W-1 -: WORD_W].
  always_comb begin
    ram_flat = '0;
    for (int i = 0; i < RAM_SIZE; i++) ram_flat[i*WORD_W +: WORD_W] = mem_q[i];
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot and run controller for the cpu core: streams a program into boot_store,
// holds the core in reset while loading, then runs it for a bounded time.
// Optional feature macro: BOOT_CHECKSUM_EN (last word is a checksum of the load).
module boot_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_SIZE  = 16,
  parameter logic [15:0] RUN_LIMIT = 16'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [RAM_SIZE*WORD_W-1:0] ram_flat,
  output logic                       cpu_reset,
  output logic                       cpu_clk_en,
  output logic [1:0]                 state,
  output logic [15:0]                run_clks,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned   AW        = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_SIZE - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q;
  logic [15:0]   run_clks_q;
  logic          cpu_reset_q, done_q;
  logic          hs, load_end, limit_hit, ck_fail, store_we;

  assign hs        = in_valid && (state_q == ST_LOAD);
  assign load_end  = hs && (in_last || (wptr_q == LAST_ADDR));
  assign limit_hit = (RUN_LIMIT != 16'd0) && (run_clks_q == RUN_LIMIT - 16'd1);

`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
  logic              error_q;

  // The in_last word is the checksum: compared, never stored.
  assign ck_fail  = hs && in_last && (in_data != sum_q);
  assign store_we = hs && !in_last && !start;
  assign error    = error_q;

  // Running mod-2^32 sum of stored words and the sticky checksum error flag.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (hs) sum_q <= sum_q + in_data;
      if (ck_fail) error_q <= 1'b1;
    end
  end
`else
  assign ck_fail  = 1'b0;
  assign store_we = hs && !start;
  assign error    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; start overrides every other event.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: if (load_end) state_d = ck_fail ? ST_HALT : ST_RUN;
        ST_RUN:  if (stop || limit_hit) state_d = ST_HALT;
        default: state_d = state_q;
      endcase
    end
  end

  // Unregistered outputs decode the state register only.
  always_comb begin
    in_ready   = (state_q == ST_LOAD);
    cpu_clk_en = (state_q == ST_RUN);
  end

  // Write pointer, run counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      run_clks_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      cpu_reset_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      done_q      <= (state_d == ST_HALT);
      if (start) begin
        wptr_q     <= '0;
        run_clks_q <= '0;
      end else begin
        if (hs) wptr_q <= wptr_q + 1'b1;
        if ((state_q == ST_RUN) && (run_clks_q != 16'hFFFF)) run_clks_q <= run_clks_q + 16'd1;
      end
    end
  end

  boot_store #(
    .RAM_SIZE (RAM_SIZE),
    .AW       (AW)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .we       (store_we),
    .waddr    (wptr_q),
    .wdata    (in_data),
    .ram_flat (ram_flat)
  );

  assign state     = state_q;
  assign run_clks  = run_clks_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer (RAM_SIZE=16, RUN_LIMIT=25).
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum variant.
module tb_boot_sequencer;

  localparam int unsigned RAM   = 16;
  localparam logic [15:0] LIMIT = 16'd25;

  logic              clk = 1'b0;
  logic              reset, start, stop, in_valid, in_last;
  logic [31:0]       in_data;
  logic              in_ready, cpu_reset, cpu_clk_en, done, error;
  logic [RAM*32-1:0] ram_flat;
  logic [1:0]        state;
  logic [15:0]       run_clks;

  boot_sequencer #(
    .RAM_SIZE  (RAM),
    .RUN_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .ram_flat   (ram_flat),
    .cpu_reset  (cpu_reset),
    .cpu_clk_en (cpu_clk_en),
    .state      (state),
    .run_clks   (run_clks),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [$];
  logic [31:0] exp_mem [RAM];
  logic [1:0]  exp_state;
  logic        exp_error;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RAM*32-1:0] exp_flat();
    logic [RAM*32-1:0] f = '0;
    for (int i = 0; i < RAM; i++) f[i*32 +: 32] = exp_mem[i];
    return f;
  endfunction

  // Reference: where the words of prog land and how the load ends.
  task automatic model_load(input bit last);
    logic [31:0] sum = '0;
    int n = (prog.size() > RAM) ? RAM : prog.size();
    for (int i = 0; i < RAM; i++) exp_mem[i] = '0;
    exp_state = 2'd2;
    exp_error = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef BOOT_CHECKSUM_EN
      if (last && i == prog.size() - 1) begin
        if (prog[i] != sum) begin
          exp_state = 2'd3;
          exp_error = 1'b1;
        end
      end else begin
        exp_mem[i] = prog[i];
        sum += prog[i];
      end
`else
      exp_mem[i] = prog[i];
`endif
    end
  endtask

  // Random program of n words; the final word is a valid checksum when enabled.
  task automatic make_prog(input int n);
    logic [31:0] s = '0;
    prog = {};
    for (int i = 0; i < n - 1; i++) begin
      prog.push_back($urandom);
      s += prog[i];
    end
`ifdef BOOT_CHECKSUM_EN
    prog.push_back(s);
`else
    prog.push_back($urandom);
`endif
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before each word, 2 random gaps.
  task automatic drive_load(input bit last, input int gap_mode);
    foreach (prog[i]) begin
      int g = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      in_valid = 1'b0;
      repeat (g) tick();
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = last && (i == prog.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en got %b want 0", cpu_clk_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (ram_flat !== '0) begin errors++; $display("FAIL rst_ram got %h want 0", ram_flat); end
    checks++; if (run_clks !== 16'd0) begin errors++; $display("FAIL rst_run_clks got %0d want 0", run_clks); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b want 00", done, error); end
    // Words offered in IDLE must be ignored.
    in_valid = 1'b1; in_data = $urandom | 32'h1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (ram_flat !== '0 || state !== 2'd0) begin errors++; $display("FAIL idle_ignore got st=%0d ram=%h want st=0 ram=0", state, ram_flat); end
    // Reset in the middle of a run.
    pulse_start();
    make_prog(4);
    drive_load(1'b1, 0);
    repeat (3) tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_rst_run got %0d want 2", state); end
    reset = 1'b1;
    tick();
    checks++; if (state !== 2'd0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL midrun_rst got st=%0d cr=%b want st=0 cr=1", state, cpu_reset); end
    checks++; if (ram_flat !== '0 || run_clks !== 16'd0) begin errors++; $display("FAIL midrun_rst_clr got ram=%h rc=%0d want 0", ram_flat, run_clks); end
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    pulse_start();
    checks++; if (state !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL start_load got st=%0d rdy=%b want 1 1", state, in_ready); end
    prog = {32'h11111111, 32'h22222222, 32'h33333333};
    model_load(1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = prog[i]; in_last = (i == 2);
      tick();
      if (i < 2) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_still_load got %0d want 1", state); end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (state !== exp_state) begin errors++; $display("FAIL basic_state got %0d want %0d", state, exp_state); end
    checks++; if (cpu_reset !== 1'b0 || cpu_clk_en !== 1'b1) begin errors++; $display("FAIL basic_run_ctl got cr=%b en=%b want 0 1", cpu_reset, cpu_clk_en); end
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL basic_ram got %h want %h", ram_flat, exp_flat()); end
  endtask

  task automatic test_full_store();
    pulse_start();
    prog = {};
    for (int i = 0; i < RAM; i++) prog.push_back($urandom);
    model_load(1'b0);
    drive_load(1'b0, 1);
    checks++; if (state !== 2'd2 || cpu_reset !== 1'b0) begin errors++; $display("FAIL full_run got st=%0d cr=%b want 2 0", state, cpu_reset); end
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL full_ram got %h want %h", ram_flat, exp_flat()); end
    in_valid = 1'b1; in_data = ~prog[0];
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_17th_ready got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL full_17th_ram got %h want %h", ram_flat, exp_flat()); end
  endtask

  task automatic test_run_limit();
    int en = 0;
    pulse_start();
    make_prog(int'($urandom_range(1, 8)));
    model_load(1'b1);
    drive_load(1'b1, 2);
    for (int c = 0; c < 40; c++) begin
      if (cpu_clk_en === 1'b1) en++;
      tick();
    end
    checks++; if (en != int'(LIMIT)) begin errors++; $display("FAIL limit_cycles got %0d want %0d", en, LIMIT); end
    checks++; if (state !== 2'd3 || done !== 1'b1) begin errors++; $display("FAIL limit_halt got st=%0d done=%b want 3 1", state, done); end
    checks++; if (run_clks !== LIMIT) begin errors++; $display("FAIL limit_run_clks got %0d want %0d", run_clks, LIMIT); end
    checks++; if (cpu_reset !== 1'b0 || cpu_clk_en !== 1'b0) begin errors++; $display("FAIL limit_ctl got cr=%b en=%b want 0 0", cpu_reset, cpu_clk_en); end
    repeat (5) tick();
    checks++; if (run_clks !== LIMIT || done !== 1'b1) begin errors++; $display("FAIL limit_hold got rc=%0d done=%b want %0d 1", run_clks, done, LIMIT); end
  endtask

  task automatic test_stop_start();
    int stops [2];
    stops[0] = 5;
    stops[1] = int'($urandom_range(1, 20));
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      make_prog(int'($urandom_range(2, 6)));
      model_load(1'b1);
      drive_load(1'b1, 0);
      repeat (stops[k] - 1) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd3 || done !== 1'b1) begin errors++; $display("FAIL stop_halt got st=%0d done=%b want 3 1", state, done); end
      checks++; if (run_clks !== 16'(stops[k])) begin errors++; $display("FAIL stop_run_clks got %0d want %0d", run_clks, stops[k]); end
      pulse_start();
      checks++; if (state !== 2'd1 || in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart got st=%0d rdy=%b done=%b want 1 1 0", state, in_ready, done); end
      checks++; if (ram_flat !== '0 || run_clks !== 16'd0) begin errors++; $display("FAIL restart_clr got ram=%h rc=%0d want 0", ram_flat, run_clks); end
    end
    make_prog(3);
    drive_load(1'b1, 0);
    repeat (3) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (state !== 2'd1 || ram_flat !== '0 || run_clks !== 16'd0) begin errors++; $display("FAIL start_stop got st=%0d rc=%0d want st=1 rc=0 ram=0", state, run_clks); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    make_prog(3);
    in_valid = 1'b1; in_data = prog[0]; in_last = 1'b0;
    tick();
    // start collides with the completing handshake and must win.
    in_data = prog[1]; in_last = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (state !== 2'd1 || ram_flat !== '0) begin errors++; $display("FAIL start_vs_last got st=%0d ram=%h want 1 0", state, ram_flat); end
    make_prog(5);
    model_load(1'b1);
    drive_load(1'b1, 0);
    checks++; if (state !== exp_state || error !== exp_error) begin errors++; $display("FAIL b2b_state got st=%0d err=%b want %0d %b", state, error, exp_state, exp_error); end
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL b2b_ram got %h want %h", ram_flat, exp_flat()); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    prog = {32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    model_load(1'b1);
    drive_load(1'b1, 0);
    checks++; if (state !== 2'd2 || error !== 1'b0) begin errors++; $display("FAIL ck_good got st=%0d err=%b want 2 0", state, error); end
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL ck_good_ram got %h want %h", ram_flat, exp_flat()); end
    pulse_start();
    prog = {32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    model_load(1'b1);
    drive_load(1'b1, 0);
    checks++; if (state !== 2'd3 || error !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL ck_bad got st=%0d err=%b done=%b want 3 1 1", state, error, done); end
    checks++; if (run_clks !== 16'd0 || cpu_clk_en !== 1'b0) begin errors++; $display("FAIL ck_bad_run got rc=%0d en=%b want 0 0", run_clks, cpu_clk_en); end
    checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL ck_bad_ram got %h want %h", ram_flat, exp_flat()); end
    for (int t = 0; t < 4; t++) begin
      pulse_start();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL ck_err_clear got %b want 0", error); end
      make_prog(int'($urandom_range(1, 10)));
      if ($urandom_range(0, 1) == 1) prog[prog.size()-1] ^= 32'h1 << $urandom_range(0, 31);
      model_load(1'b1);
      drive_load(1'b1, 2);
      checks++; if (state !== exp_state || error !== exp_error) begin errors++; $display("FAIL ck_rand got st=%0d err=%b want %0d %b", state, error, exp_state, exp_error); end
      checks++; if (ram_flat !== exp_flat()) begin errors++; $display("FAIL ck_rand_ram got %h want %h", ram_flat, exp_flat()); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_full_store();
    test_run_limit();
    test_stop_start();
    test_back_to_back();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Boot and run controller for the `cpu` core. It accepts a program as a stream of 32-bit words and writes it into a `RAM_SIZE` x 32 program store, which it presents to the core as the flattened `ram` bus. It holds the core in reset while loading, then releases it and gates its clock for a bounded run. It replaces testbench-side `$readmemh` loading and fixed-delay `$finish` with a synthesizable sequence.

## Interface

Parameters:
- `RAM_SIZE`, 16: program words; address width `AW = $clog2(RAM_SIZE)`.
- `RUN_LIMIT`, 16'd0: number of RUN cycles before an automatic halt; 0 means unlimited.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse; begins a (re)load from any state.
- `stop`  in  1: level; forces RUN → HALT.
- `in_valid`  in  1: program word valid.
- `in_data`  in  32: program word.
- `in_last`  in  1: marks the final word of the program.
- `in_ready`  out  1: ready to accept a word.
- `ram_flat`  out  `RAM_SIZE*32`: program store; word i is at `[(i+1)*32-1 -: 32]`.
- `cpu_reset`  out  1: drives the core's `reset`.
- `cpu_clk_en`  out  1: core clock enable.
- `state`  out  2: IDLE=0, LOAD=1, RUN=2, HALT=3.
- `run_clks`  out  16: RUN cycles elapsed.
- `done`  out  1: high in HALT.
- `error`  out  1: checksum failure (see Configuration).

## Operation

- IDLE:
  - `cpu_reset=1`, `cpu_clk_en=0`, `in_ready=0`.
  - `start` → LOAD.
- Entry to LOAD (from any state on `start`):
  - All store words cleared to 0.
  - `wptr=0`, `run_clks=0`, `error=0`.
- LOAD:
  - `in_ready=1`, `cpu_reset=1`.
  - Each handshake (`in_valid & in_ready`) writes `in_data` to word `wptr`, then `wptr++`.
  - The load ends on a handshake with `in_last=1`, or on the handshake at `wptr==RAM_SIZE-1`, whichever comes first. It then goes to RUN.
  - Words beyond the last written word remain 0.
- RUN:
  - `cpu_reset=0`, `cpu_clk_en=1`, `in_ready=0`.
  - `run_clks` increments every cycle, saturating at 16'hFFFF.
  - Goes to HALT when `stop=1`, or when `RUN_LIMIT!=0` and `run_clks==RUN_LIMIT-1` on that cycle, so exactly `RUN_LIMIT` enabled cycles occur.
- HALT:
  - `cpu_clk_en=0`, `cpu_reset=0`, so core state is frozen and observable.
  - `done=1`; `run_clks` holds.
  - `start` → LOAD.
- Simultaneous events:
  - `start` has priority over `stop`, limit expiry, and load completion.
  - `stop` in LOAD or IDLE is ignored.
  - `in_valid` outside LOAD is ignored.
- `reset`: every state → IDLE next edge, including mid-load and mid-run.
  - Store cleared, `wptr=0`, `run_clks=0`, `done=0`, `error=0`.

## Timing

- Reset values: `state=IDLE`, `cpu_reset=1`, `cpu_clk_en=0`, `in_ready=0`, `ram_flat=0`, `run_clks=0`, `done=0`, `error=0`.
- `start` sampled at edge N: LOAD from cycle N+1, with `in_ready=1` in the same cycle.
- Final handshake at edge M:
  - The word is visible on `ram_flat` after M.
  - `state=RUN`, `cpu_reset=0`, `cpu_clk_en=1` from cycle M+1.
  - The core's first fetch is therefore at edge M+1.
- Load throughput is one word per cycle; `in_ready` has no wait states.
- All outputs are registered, except `in_ready` and `cpu_clk_en`, which decode the state register only.

## Configuration

- `BOOT_CHECKSUM_EN` defined:
  - The word carrying `in_last` is a checksum. It is not written to the store.
  - It must equal the mod-2^32 sum of all preceding words of the load.
  - On mismatch: go to HALT instead of RUN, `error=1`, `run_clks=0`.
  - A load ended by filling `RAM_SIZE` words without `in_last` skips the check.
- `BOOT_CHECKSUM_EN` undefined:
  - The `in_last` word is stored as ordinary data.
  - `error` is tied 0; no adder is present.

## Structure

- Shared package `cpu_pkg`:
  - State encoding localparams `ST_IDLE/ST_LOAD/ST_RUN/ST_HALT`.
  - Word width constant `WORD_W=32`.
- One sub-module, `boot_store`: the `RAM_SIZE` x 32 register array with write port, clear, and flattened output.
- The FSM, counters and checksum stay in `boot_sequencer`.

## Test plan

- Reset:
  - Hold `reset` 3 cycles during RUN.
  - Expect `state=0`, `cpu_reset=1`, `ram_flat=0`, `run_clks=0` after the next edge.
- Basic load:
  - `start`, then 3 words 0x11111111, 0x22222222, 0x33333333 (last on the third).
  - Expect words 0–2 set, words 3–15 zero.
  - Expect RUN and `cpu_reset=0` exactly one cycle after the third handshake.
- Full store:
  - 16 words with no `in_last`, `in_valid` toggled every other cycle.
  - Expect all 16 words stored and RUN after the 16th handshake.
  - A 17th word must not be accepted (`in_ready=0`).
- Run limit:
  - `RUN_LIMIT=25`.
  - Expect exactly 25 cycles with `cpu_clk_en=1`, then `done=1` and `run_clks=25` holding.
- `stop` / `start`:
  - `stop` at RUN cycle 5 → HALT with `run_clks=5`.
  - Then `start` → LOAD with store cleared and `run_clks=0`.
  - `start` and `stop` in the same RUN cycle → LOAD.
- Checksum (`BOOT_CHECKSUM_EN`):
  - Data 0x00000001, 0xFFFFFFFF with checksum 0x00000000 → RUN.
  - Same data with checksum 0x00000001 → HALT, `error=1`, checksum not stored.
